// File: rtl/fmap_bram_reader.sv
// ---------------------------------------------------------------------------
// fmap_bram_reader
//   Reads the layer-1 output feature map back out of the dual-port BRAM32k
//   and streams it to the next layer as two 64-bit words per beat.
//   Port 1 fetches even word offsets and port 2 fetches odd offsets. A
//   RD_LAT-deep tracking pipe follows each issued pair through the BRAM. An
//   output FIFO then absorbs downstream backpressure. Its head is the
//   registered m_* stage.
//
// Optional build macro:
//   FMAP_READER_RELU_EN - when defined, each int8 lane is clamped to 0 if it
//                         is negative. The clamp is applied as data enters
//                         the FIFO and adds no latency. When undefined, data
//                         passes through bit-exact.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 launch a job (sampled only when idle)
//   base_addr, num_words  job first word address and length in words
//   busy, done            job in progress / 1-cycle completion pulse
//   we_BRAM32k            tied low (read-only engine)
//   addr_BRAM32k_1/2      even/odd read addresses
//   dout_BRAM32k_1/2      even/odd read data
//   m_valid, m_ready      output stream handshake
//   m_data, m_keep        {odd, even} words and per-word valid
//   m_last                final beat of the job
// ---------------------------------------------------------------------------
module fmap_bram_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1,
   parameter int FIFO_D = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     num_words,
   output logic                busy,
   output logic                done,
   output logic                we_BRAM32k,
   output logic [ADDR_W-1:0]   addr_BRAM32k_1,
   output logic [ADDR_W-1:0]   addr_BRAM32k_2,
   input  logic [DATA_W-1:0]   dout_BRAM32k_1,
   input  logic [DATA_W-1:0]   dout_BRAM32k_2,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [2*DATA_W-1:0] m_data,
   output logic [1:0]          m_keep,
   output logic                m_last
);

   localparam int CNT_W = $clog2(FIFO_D + RD_LAT + 1);
   localparam int SD    = FIFO_D - 1;                  // storage behind the output register
   localparam int PW    = (SD > 1) ? $clog2(SD) : 1;
   localparam int EW    = 2*DATA_W + 3;                // {last, keep, data}

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   state_t              state;
   logic [ADDR_W:0]     left;                          // words still to issue
   logic                pv [RD_LAT];
   logic                pl [RD_LAT];
   logic [1:0]          pk [RD_LAT];
   logic [CNT_W-1:0]    occ;                           // beats held, output register included
   logic [CNT_W-1:0]    inflight;
   logic [CNT_W-1:0]    stor_cnt;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [EW-1:0]       stor [SD];
   logic                issue;
   logic                last_pair;
   logic [1:0]          issue_keep;
   logic                pop;
   logic                wr;
   logic                load_out;
   logic                direct;
   logic [2*DATA_W-1:0] raw_data;
   logic [2*DATA_W-1:0] wr_data;

`ifdef FMAP_READER_RELU_EN
   function automatic logic [2*DATA_W-1:0] relu_lanes(input logic [2*DATA_W-1:0] d);
      logic [2*DATA_W-1:0] r;
      r = d;
      for (int i = 0; i < (2*DATA_W)/8; i++) begin
         if (d[8*i+7]) begin
            r[8*i +: 8] = 8'h00;
         end
      end
      return r;
   endfunction
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SD-1)) ? '0 : p + PW'(1);
   endfunction

   assign we_BRAM32k = 1'b0;

   // Count pairs currently travelling through the BRAM read latency.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNT_W'(pv[i]);
      end
   end

   // The issue budget counts in-flight reads, so the FIFO can never overflow.
   assign issue      = (state == READ) && ((occ + inflight) < CNT_W'(FIFO_D));
   assign last_pair  = (left <= (ADDR_W+1)'(2));
   assign issue_keep = (left == (ADDR_W+1)'(1)) ? 2'b01 : 2'b11;

   assign pop      = m_valid && m_ready;
   assign wr       = pv[RD_LAT-1];
   assign stor_cnt = occ - CNT_W'(m_valid);
   assign load_out = !m_valid || pop;
   assign direct   = load_out && (stor_cnt == '0) && wr;
   assign raw_data = {(pk[RD_LAT-1][1] ? dout_BRAM32k_2 : {DATA_W{1'b0}}), dout_BRAM32k_1};

`ifdef FMAP_READER_RELU_EN
   assign wr_data = relu_lanes(raw_data);
`else
   assign wr_data = raw_data;
`endif

   // Job control FSM: address generation, busy and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         left           <= '0;
         addr_BRAM32k_1 <= '0;
         addr_BRAM32k_2 <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (num_words == '0) begin
                     state <= FIN;
                  end else begin
                     addr_BRAM32k_1 <= base_addr;
                     // A single-word job leaves port 2 on its previous address.
                     if (num_words >= (ADDR_W+1)'(2)) begin
                        addr_BRAM32k_2 <= base_addr + ADDR_W'(1);
                     end
                     left  <= num_words;
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  if (last_pair) begin
                     left  <= '0;
                     state <= DRAIN;
                  end else begin
                     left           <= left - (ADDR_W+1)'(2);
                     addr_BRAM32k_1 <= addr_BRAM32k_1 + ADDR_W'(2);
                     // Next pair is full only if at least two words remain after it.
                     if (left > (ADDR_W+1)'(3)) begin
                        addr_BRAM32k_2 <= addr_BRAM32k_1 + ADDR_W'(3);
                     end
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end
            end
            FIN: begin
               // Entered with done=1 from DRAIN; an empty job sets it here first.
               busy <= 1'b0;
               done <= ~done;
               if (done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Return-path tracker: one stage per cycle of BRAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pv[i] <= 1'b0;
            pl[i] <= 1'b0;
            pk[i] <= 2'b00;
         end
      end else begin
         pv[0] <= issue;
         pl[0] <= last_pair;
         pk[0] <= issue_keep;
         for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pl[i] <= pl[i-1];
            pk[i] <= pk[i-1];
         end
      end
   end

   // Output register (FIFO head) plus occupancy and storage pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_keep  <= 2'b00;
         m_last  <= 1'b0;
         occ     <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         occ <= occ + CNT_W'(wr) - CNT_W'(pop);
         if (load_out) begin
            if (stor_cnt != '0) begin
               m_valid                  <= 1'b1;
               {m_last, m_keep, m_data} <= stor[rd_ptr];
               rd_ptr                   <= ptr_inc(rd_ptr);
            end else if (wr) begin
               m_valid                  <= 1'b1;
               {m_last, m_keep, m_data} <= {pl[RD_LAT-1], pk[RD_LAT-1], wr_data};
            end else begin
               m_valid <= 1'b0;
            end
         end
         if (wr && !direct) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
      end
   end

   // FIFO storage array (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (wr && !direct) begin
         stor[wr_ptr] <= {pl[RD_LAT-1], pk[RD_LAT-1], wr_data};
      end
   end

endmodule

// File: tb/tb_fmap_bram_reader.sv
module tb_fmap_bram_reader;

   localparam int RD_LAT = 2;

   typedef struct packed {
      logic         l;
      logic [1:0]   k;
      logic [127:0] d;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [11:0]  base_addr = '0;
   logic [12:0]  num_words = '0;
   logic         busy, done, we;
   logic [11:0]  addr1, addr2;
   logic [63:0]  dout1, dout2;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [127:0] m_data;
   logic [1:0]   m_keep;
   logic         m_last;

   logic [63:0]  mem [4096];
   logic [63:0]  d1_1, d1_2, d2_1, d2_2;

   beat_t        q[$];
   int           n_chk = 0, n_err = 0;
   int           cyc = 0;
   int           rdy_mode = 0;
   int           beats_seen = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
   int           exp_first = 0;
   bit           wait_first = 0, valid_seen = 0, stall_prev = 0;
   beat_t        stall_beat;

   fmap_bram_reader #(.ADDR_W(12), .DATA_W(64), .RD_LAT(RD_LAT), .FIFO_D(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .busy(busy), .done(done), .we_BRAM32k(we),
      .addr_BRAM32k_1(addr1), .addr_BRAM32k_2(addr2),
      .dout_BRAM32k_1(dout1), .dout_BRAM32k_2(dout2),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model with selectable read latency
   always @(posedge clk) begin
      d1_1 <= mem[addr1];
      d1_2 <= mem[addr2];
      d2_1 <= d1_1;
      d2_2 <= d1_2;
   end
   assign dout1 = (RD_LAT == 2) ? d2_1 : d1_1;
   assign dout2 = (RD_LAT == 2) ? d2_2 : d1_2;

   function automatic logic [63:0] pattern(input logic [11:0] a);
      return {16'h1357, 4'h0, a, 16'h2468, 4'h0, a};
   endfunction

   function automatic logic [63:0] exp_word(input logic [11:0] a);
      logic [63:0] w;
      w = (a == 12'd300) ? 64'h80FF7F01_00FE0203 : pattern(a);
`ifdef FMAP_READER_RELU_EN
      if (a == 12'd300) begin
         w = 64'h00007F01_00000203;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if ($signed(w[8*i +: 8]) < 0) w[8*i +: 8] = 8'h00;
         end
      end
`endif
      return w;
   endfunction

   task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Ready pattern: 0 = always ready, 1 = toggle, 2 = low 2 of every 5 cycles
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1)      m_ready = ~m_ready;
         else if (rdy_mode == 2) m_ready = ((cyc % 5) >= 2);
         else                    m_ready = 1'b1;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      beat_t b;
      if (!rst) begin
         if (m_valid) valid_seen = 1;
         if (wait_first && m_valid) begin
            chk("first_valid_cycle", cyc, exp_first);
            wait_first = 0;
         end
         if (stall_prev) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_stable", {m_last, m_keep, m_data}, stall_beat);
         end
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_beat: got %h expected none", m_data);
            end else begin
               b = q.pop_front();
               chk("beat_data", m_data, b.d);
               chk("beat_keep", m_keep, b.k);
               chk("beat_last", m_last, b.l);
            end
            beats_seen++;
            if (m_last) last_cyc = cyc;
         end
         stall_prev = m_valid && !m_ready;
         stall_beat = {m_last, m_keep, m_data};
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         stall_prev = 0;
      end
   end

   task automatic push_beats(input logic [11:0] base, input int len);
      beat_t b;
      for (int k = 0; k < len; k += 2) begin
         b.d[63:0] = exp_word(base + 12'(k));
         if (k + 1 < len) begin
            b.d[127:64] = exp_word(base + 12'(k + 1));
            b.k = 2'b11;
         end else begin
            b.d[127:64] = 64'h0;
            b.k = 2'b01;
         end
         b.l = (k + 2 >= len);
         q.push_back(b);
      end
   endtask

   task automatic run_job(input logic [11:0] base, input int len, input int mode, input bit poke);
      int t;
      rdy_mode = mode;
      beats_seen = 0;
      done_cnt = 0;
      valid_seen = 0;
      push_beats(base, len);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = base;
      num_words = 13'(len);
      t = cyc;
      exp_first = t + 2 + RD_LAT;
      wait_first = (len != 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      base_addr = 12'hABC;
      num_words = 13'h1FFF;
      @(negedge clk);
      chk("busy_after_start", busy, 1'b1);
      if (poke) begin
         @(posedge clk);
         #1;
         start = 1'b1;
         num_words = 13'd0;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
      chk("done_seen", done_cnt, 1);
      if (len == 0) chk("done_cycle_empty", done_cyc, t + 2);
      else          chk("done_cycle", done_cyc, last_cyc + 1);
      repeat (4) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("busy_after_done", busy, 1'b0);
      chk("queue_empty", q.size(), 0);
      chk("beat_count", beats_seen, (len + 1) / 2);
      if (len == 0) chk("no_valid_empty_job", valid_seen, 1'b0);
      rdy_mode = 0;
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = pattern(12'(a));
      mem[300] = 64'h80FF7F01_00FE0203;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {busy, done, m_valid, m_keep, m_last, we}, 7'd0);
      chk("rst_data", m_data, 128'd0);
      chk("rst_addr", {addr1, addr2}, 24'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_job(12'd0, 8, 0, 1'b1);
      run_job(12'd4094, 4, 0, 1'b0);
      run_job(12'd20, 5, 0, 1'b0);
      run_job(12'd40, 16, 1, 1'b0);
      run_job(12'd100, 11, 2, 1'b0);
      run_job(12'd0, 0, 0, 1'b0);
      run_job(12'd300, 1, 0, 1'b0);

      // Reset in the middle of a long job
      beats_seen = 0;
      push_beats(12'd500, 32);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 12'd500;
      num_words = 13'd32;
      exp_first = cyc + 2 + RD_LAT;
      wait_first = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 100 && beats_seen < 3; i++) @(negedge clk);
      chk("beats_before_reset", beats_seen >= 3, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_valid", m_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      wait_first = 0;
      done_cnt = 0;
      beats_seen = 0;
      repeat (20) @(negedge clk);
      chk("no_done_after_reset", done_cnt, 0);
      chk("no_beats_after_reset", beats_seen, 0);
      run_job(12'd10, 2, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
